// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD,
      ST_TAG,
      ST_START,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_GAP
   } state_t;

   localparam logic [3:0] UART_TAG_NIBBLE = 4'hA;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = IDW'((32'(ptr) + k) % NREQ);
         if (!any && req[pos]) begin
            any   = 1'b1;
            idx   = pos;
            grant = NREQ'(1) << pos;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers.
// Optional header byte per grant when UART_TX_SCHED_TAG_EN is defined.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned GAP_CYC = 2,
   parameter  int unsigned TMO_CYC = 16,
   localparam int unsigned IDW     = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [IDW-1:0]    grant_id,
   output logic              active,
   output logic              tmo_err
);

   localparam int unsigned CNTW = clog2(TMO_CYC + GAP_CYC + 2) + 1;

   state_t          state, nxt;
   logic [IDW-1:0]  ptr;
   logic [CNTW-1:0] cnt;
   logic [NREQ-1:0] grant_oh;
   logic [NREQ-1:0] arb_grant;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic [7:0]      sel_byte;
   logic            timeout;
   logic            gap_done;
`ifdef UART_TX_SCHED_TAG_EN
   logic [7:0]      payload_q;
   logic            hdr_phase;
`endif

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign sel_byte = 8'(req_data >> (8 * grant_id));
   // cnt numbers the no-busy cycles with the tx_start cycle as 1
   assign timeout  = !tx_busy && (cnt >= CNTW'(TMO_CYC));
   assign gap_done = cnt >= CNTW'(GAP_CYC);

   always_comb begin
      nxt       = state;
      req_ready = '0;
      tx_start  = 1'b0;
      case (state)
         ST_IDLE:    if (|req_valid && !tx_busy) nxt = ST_ARB;
         ST_ARB:     nxt = arb_any ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            req_ready = grant_oh;
`ifdef UART_TX_SCHED_TAG_EN
            nxt = ST_TAG;
`else
            nxt = ST_START;
`endif
         end
         ST_TAG:     nxt = ST_START;
         ST_START: begin
            tx_start = 1'b1;
            nxt      = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (tx_busy)      nxt = ST_WAIT_LO;
            else if (timeout) nxt = ST_GAP;
         end
         ST_WAIT_LO: begin
            if (!tx_busy) begin
               nxt = ST_GAP;
`ifdef UART_TX_SCHED_TAG_EN
               if (hdr_phase) nxt = ST_START;
`endif
            end
         end
         ST_GAP:     if (gap_done) nxt = ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         grant_id <= '0;
         grant_oh <= '0;
         tx_data  <= '0;
         active   <= 1'b0;
         tmo_err  <= 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
         payload_q <= '0;
         hdr_phase <= 1'b0;
`endif
      end else begin
         state <= nxt;
         case (nxt)
            ST_WAIT_HI: cnt <= (state == ST_START) ? CNTW'(2) : cnt + 1'b1;
            ST_GAP:     cnt <= (state == ST_GAP) ? cnt + 1'b1 : CNTW'(1);
            default:    cnt <= '0;
         endcase
         case (state)
            ST_ARB: begin
               if (arb_any) begin
                  grant_id <= arb_idx;
                  grant_oh <= arb_grant;
                  active   <= 1'b1;
                  ptr      <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
               end
            end
`ifdef UART_TX_SCHED_TAG_EN
            ST_LOAD: payload_q <= sel_byte;
            ST_TAG: begin
               tx_data   <= {UART_TAG_NIBBLE, 1'b0, 3'(grant_id)};
               hdr_phase <= 1'b1;
            end
            // header timeout drops the payload as well
            ST_WAIT_HI: begin
               if (timeout) begin
                  tmo_err   <= 1'b1;
                  hdr_phase <= 1'b0;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_busy && hdr_phase) begin
                  tx_data   <= payload_q;
                  hdr_phase <= 1'b0;
               end
            end
`else
            ST_LOAD:    tx_data <= sel_byte;
            ST_WAIT_HI: if (timeout) tmo_err <= 1'b1;
`endif
            ST_GAP:     if (gap_done) active <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a behavioural transmitter core.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned GAP_CYC = 2;
   localparam int unsigned TMO_CYC = 16;
`ifdef UART_TX_SCHED_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        tmo_err;

   int n_vec = 0;
   int n_err = 0;
   int ref_ptr = 0;
   int start_ofs;
   logic [7:0] sent_q[$];
   logic [7:0] exp_q[$];

   int unsigned busy_cnt = 0;
   int unsigned frame_len = 10;
   bit core_dead = 1'b0;
   bit force_busy = 1'b0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .active    (active),
      .tmo_err   (tmo_err)
   );

   // Transmitter core: busy rises the cycle after tx_start, lasts frame_len cycles
   always @(posedge clk) begin
      if (rst) busy_cnt <= 0;
      else if (tx_start === 1'b1 && !core_dead) busy_cnt <= frame_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = force_busy || (busy_cnt != 0);

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         sent_q.push_back(tx_data);
         frame_len = $urandom_range(4, 100);
      end
   end

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic void push_exp(input int g, input logic [7:0] d);
      if (TAG) exp_q.push_back({4'hA, 1'b0, 3'(g)});
      exp_q.push_back(d);
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      do begin
         step();
         c++;
      end while (!(active === 1'b0 && tx_busy === 1'b0) && c < 500);
      if (c >= 500) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_wait: still active after %0d cycles, required idle", c);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (3) step();
      rst = 1'b0;
      ref_ptr = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'hF;
      req_data = $urandom;
      repeat (3) begin
         step();
         n_vec++;
         if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", tx_start); end
      end
      n_vec++;
      if (req_ready !== 4'h0 || tx_data !== 8'h00 || grant_id !== 2'd0 ||
          active !== 1'b0 || tmo_err !== 1'b0) begin
         n_err++;
         $display("FAIL rst_outputs: ready=%h data=%h gid=%0d act=%b tmo=%b, want all 0",
                  req_ready, tx_data, grant_id, active, tmo_err);
      end
      req_valid = '0;
      rst = 1'b0;
      ref_ptr = 0;
   endtask

   task automatic test_single();
      int c, rdy_c, st_c;
      logic [3:0] rdy_v;
      logic [1:0] gid_v;
      logic [7:0] first_b;
      wait_idle();
      sent_q.delete();
      exp_q.delete();
      req_data = $urandom;
      req_data[23:16] = 8'h5A;
      req_valid = 4'b0100;
      c = 0; rdy_c = -1; st_c = -1; rdy_v = '0; gid_v = '0; first_b = '0;
      while (st_c < 0 && c < 12) begin
         step();
         c++;
         if (rdy_c >= 0 && c == rdy_c + 1) req_valid = '0;
         if (req_ready !== 4'h0 && rdy_c < 0) begin rdy_c = c; rdy_v = req_ready; gid_v = grant_id; end
         if (tx_start === 1'b1) begin st_c = c; first_b = tx_data; end
      end
      req_valid = '0;
      push_exp(2, 8'h5A);
      n_vec++;
      if (rdy_c != 2 || rdy_v !== 4'b0100) begin n_err++; $display("FAIL single_ready: cycle %0d vec %b, want cycle 2 vec 0100", rdy_c, rdy_v); end
      n_vec++;
      if (gid_v !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", gid_v); end
      n_vec++;
      if (st_c != start_ofs) begin n_err++; $display("FAIL single_start_lat: got %0d want %0d", st_c, start_ofs); end
      n_vec++;
      if (first_b !== exp_q[0]) begin n_err++; $display("FAIL single_first_byte: got %h want %h", first_b, exp_q[0]); end
      wait_idle();
      n_vec++;
      if (sent_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      ref_ptr = 3;
   endtask

   task automatic test_fairness();
      int k, c, pend, e;
      do_reset();
      sent_q.delete();
      exp_q.delete();
      req_data = $urandom;
      req_valid = 4'hF;
      k = 0; c = 0; pend = -1;
      while (k < 8 && c < 3000) begin
         step();
         c++;
         if (pend >= 0) begin req_data[8*pend +: 8] = 8'($urandom); pend = -1; end
         if (req_ready !== 4'h0) begin
            e = k % 4;
            n_vec++;
            if (req_ready !== 4'(1 << e) || grant_id !== 2'(e)) begin
               n_err++;
               $display("FAIL fair_grant%0d: ready=%b gid=%0d want gid %0d", k, req_ready, grant_id, e);
            end
            push_exp(e, req_data[8*e +: 8]);
            pend = e;
            k++;
         end
      end
      step();
      req_valid = '0;
      n_vec++;
      if (k < 8) begin n_err++; $display("FAIL fair_budget: got %0d grants want 8", k); end
      wait_idle();
      n_vec++;
      if (sent_q.size() != exp_q.size()) begin n_err++; $display("FAIL fair_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fair_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      ref_ptr = 0;
   endtask

   task automatic test_timeout();
      int r, s, c, exp_n;
      logic [7:0] d2;
      wait_idle();
      core_dead = 1'b1;
      sent_q.delete();
      r = $urandom_range(0, 3);
      req_data = $urandom;
      req_valid = 4'(1 << r);
      c = 0;
      while (req_ready === 4'h0 && c < 10) begin step(); c++; end
      n_vec++;
      if (req_ready !== 4'(1 << r)) begin n_err++; $display("FAIL tmo_ready: got %b want %b", req_ready, 4'(1 << r)); end
      step();
      req_valid = '0;
      c = 0;
      while (tx_start !== 1'b1 && c < 10) begin step(); c++; end
      n_vec++;
      if (tx_start !== 1'b1) begin n_err++; $display("FAIL tmo_start: got %b want 1", tx_start); end
      c = 0;
      while (tmo_err !== 1'b1 && c < 40) begin step(); c++; end
      n_vec++;
      if (c != int'(TMO_CYC)) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", c, TMO_CYC); end
      wait_idle();
      n_vec++;
      if (sent_q.size() != 1) begin n_err++; $display("FAIL tmo_dropped: got %0d starts want 1", sent_q.size()); end
      ref_ptr = (r + 1) % 4;
      core_dead = 1'b0;
      s = (r + 2) % 4;
      d2 = 8'($urandom);
      req_data[8*s +: 8] = d2;
      req_valid = 4'(1 << s);
      c = 0;
      while (req_ready === 4'h0 && c < 10) begin step(); c++; end
      n_vec++;
      if (req_ready !== 4'(1 << s) || grant_id !== 2'(s)) begin n_err++; $display("FAIL tmo_next_grant: ready=%b gid=%0d want gid %0d", req_ready, grant_id, s); end
      step();
      req_valid = '0;
      wait_idle();
      exp_n = TAG ? 3 : 2;
      n_vec++;
      if (sent_q.size() != exp_n || sent_q[sent_q.size()-1] !== d2) begin
         n_err++;
         $display("FAIL tmo_next_byte: count %0d last %h want count %0d last %h", sent_q.size(), sent_q[sent_q.size()-1], exp_n, d2);
      end
      n_vec++;
      if (tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
      ref_ptr = (s + 1) % 4;
   endtask

   task automatic test_busy_stall();
      int c, rdy_c, st_c;
      wait_idle();
      force_busy = 1'b1;
      req_data = $urandom;
      req_valid = 4'h1;
      repeat (10) begin
         step();
         n_vec++;
         if (active !== 1'b0 || req_ready !== 4'h0 || tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: act=%b ready=%b start=%b want all 0", active, req_ready, tx_start);
         end
      end
      force_busy = 1'b0;
      c = 0; rdy_c = -1; st_c = -1;
      while (st_c < 0 && c < 12) begin
         step();
         c++;
         if (rdy_c >= 0 && c == rdy_c + 1) req_valid = '0;
         if (req_ready === 4'h1 && rdy_c < 0) rdy_c = c;
         if (tx_start === 1'b1) st_c = c;
      end
      req_valid = '0;
      n_vec++;
      if (rdy_c != 2) begin n_err++; $display("FAIL stall_ready_lat: got %0d want 2", rdy_c); end
      n_vec++;
      if (st_c != start_ofs) begin n_err++; $display("FAIL stall_start_lat: got %0d want %0d", st_c, start_ofs); end
      wait_idle();
      ref_ptr = 1;
   endtask

   task automatic test_random();
      int grants, c, exp_w, drop;
      logic [3:0] prev_vec;
      logic prev_active;
      wait_idle();
      sent_q.delete();
      exp_q.delete();
      grants = 0; c = 0; exp_w = -1; drop = -1;
      prev_vec = req_valid;
      prev_active = active;
      while ((grants < 30 || req_valid != 4'h0) && c < 20000) begin
         step();
         c++;
         if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
         if (active === 1'b1 && prev_active === 1'b0) begin
            exp_w = rr_pick(prev_vec, ref_ptr);
            n_vec++;
            if (grant_id !== 2'(exp_w)) begin n_err++; $display("FAIL rand_grant%0d: got %0d want %0d", grants, grant_id, exp_w); end
            if (exp_w >= 0) ref_ptr = (exp_w + 1) % 4;
         end
         if (req_ready !== 4'h0) begin
            n_vec++;
            if (exp_w < 0 || req_ready !== 4'(1 << exp_w)) begin
               n_err++;
               $display("FAIL rand_ready%0d: got %b want index %0d", grants, req_ready, exp_w);
            end else begin
               push_exp(exp_w, req_data[8*exp_w +: 8]);
               drop = exp_w;
            end
            grants++;
         end
         if (grants < 30 && $urandom_range(0, 3) == 0) begin
            int b;
            b = $urandom_range(0, 3);
            if (!req_valid[b] && b != drop) begin
               req_data[8*b +: 8] = 8'($urandom);
               req_valid[b] = 1'b1;
            end
         end
         prev_vec = req_valid;
         prev_active = active;
      end
      req_valid = '0;
      n_vec++;
      if (c >= 20000) begin n_err++; $display("FAIL rand_budget: %0d grants in %0d cycles", grants, c); end
      wait_idle();
      n_vec++;
      if (sent_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
   endtask

   task automatic test_mid_reset();
      int c, t;
      wait_idle();
      t = $urandom_range(0, 3);
      req_data = $urandom;
      req_valid = 4'(1 << t);
      c = 0;
      while (req_ready === 4'h0 && c < 10) begin step(); c++; end
      step();
      req_valid = '0;
      c = 0;
      while (tx_busy !== 1'b1 && c < 20) begin step(); c++; end
      n_vec++;
      if (tx_busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b want 1", tx_busy); end
      rst = 1'b1;
      step();
      n_vec++;
      if (req_ready !== 4'h0 || tx_data !== 8'h00 || tx_start !== 1'b0 || grant_id !== 2'd0 ||
          active !== 1'b0 || tmo_err !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_outputs: ready=%h data=%h start=%b gid=%0d act=%b tmo=%b, want all 0",
                  req_ready, tx_data, tx_start, grant_id, active, tmo_err);
      end
      rst = 1'b0;
      ref_ptr = 0;
      wait_idle();
   endtask

`ifdef UART_TX_SCHED_TAG_EN
   task automatic test_tag();
      int c;
      wait_idle();
      sent_q.delete();
      req_data = $urandom;
      req_data[31:24] = 8'h33;
      req_valid = 4'b1000;
      c = 0;
      while (req_ready === 4'h0 && c < 10) begin step(); c++; end
      step();
      req_valid = '0;
      wait_idle();
      n_vec++;
      if (sent_q.size() != 2) begin n_err++; $display("FAIL tag_count: got %0d want 2", sent_q.size()); end
      else begin
         if (sent_q[0] !== 8'hA3) begin n_err++; $display("FAIL tag_header: got %h want a3", sent_q[0]); end
         if (sent_q[1] !== 8'h33) begin n_err++; $display("FAIL tag_payload: got %h want 33", sent_q[1]); end
      end
      ref_ptr = 0;
   endtask
`endif

   initial begin
      start_ofs = TAG ? 4 : 3;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_busy_stall();
      test_random();
      test_mid_reset();
`ifdef UART_TX_SCHED_TAG_EN
      test_tag();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
